// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with registered one-hot grant, encoded index
// and optional hold limit that forces rotation when other clients are waiting.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } fsm_e;

  localparam bit         PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  fsm_e       fsm_q, fsm_d;
  logic [2:0] holder_q, holder_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic       others_req;
  logic       at_limit;

  // Priority scan starting at ptr; the most recent holder sits at ptr-1 and is seen last.
  always_comb begin
    logic [2:0] scan_idx;
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      scan_idx = ptr_q + 3'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign others_req = |(req & ~(8'b1 << holder_q));
  assign at_limit   = PREEMPT_EN && (hold_cnt_q >= HOLD_LIMIT);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    fsm_d       = fsm_q;
    holder_d    = holder_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;

    unique case (fsm_q)
      IDLE: begin
        if (win_found) begin
          fsm_d       = GRANT;
          holder_d    = win_idx;
          ptr_d       = win_idx + 3'd1;
          hold_cnt_d  = 8'd1;
          gnt_d       = 8'b1 << win_idx;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
        end else begin
          gnt_d       = 8'd0;
          gnt_idx_d   = 3'd0;
          gnt_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (!req[holder_q] || (at_limit && others_req)) begin
          // Release or forced rotation: re-arbitrate on this same edge, no idle bubble.
          if (win_found) begin
            holder_d    = win_idx;
            ptr_d       = win_idx + 3'd1;
            hold_cnt_d  = 8'd1;
            gnt_d       = 8'b1 << win_idx;
            gnt_idx_d   = win_idx;
            gnt_valid_d = 1'b1;
          end else begin
            fsm_d       = IDLE;
            hold_cnt_d  = 8'd0;
            gnt_d       = 8'd0;
            gnt_idx_d   = 3'd0;
            gnt_valid_d = 1'b0;
          end
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        fsm_d       = IDLE;
        gnt_d       = 8'd0;
        gnt_idx_d   = 3'd0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      holder_q    <= 3'd0;
      ptr_q       <= 3'd0;
      hold_cnt_q  <= 8'd0;
      gnt_q       <= 8'd0;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      holder_q    <= holder_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: three instances cover unlimited hold, MAX_HOLD=4
// and MAX_HOLD=2; every expected value is hand-derived from the arbitration rules.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req0 = 8'd0, req4 = 8'd0, req2 = 8'd0;
  logic [7:0] gnt0, gnt4, gnt2;
  logic [2:0] idx0, idx4, idx2;
  logic       vld0, vld4, vld2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(0)) u_nohold (
    .clk(clk), .rst_n(rst_n), .req(req0), .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(vld0)
  );
  rr_arbiter_8 #(.MAX_HOLD(4)) u_hold4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(vld4)
  );
  rr_arbiter_8 #(.MAX_HOLD(2)) u_hold2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .gnt(gnt2), .gnt_idx(idx2), .gnt_valid(vld2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({gnt0, idx0, vld0, gnt4, gnt2} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_state: gnt0=%h idx0=%0d vld0=%b gnt4=%h gnt2=%h, expected all 0",
               gnt0, idx0, vld0, gnt4, gnt2);
    end
    rst_n = 1'b1;
    step();
    req0 = 8'hFF;
    step();
    vectors++;
    if (gnt0 !== 8'h01) begin
      miscompares++;
      $display("FAIL reset_first_grant: gnt=%h expected 01", gnt0);
    end
    step();
    step();
    rst_n = 1'b0;
    #2;
    vectors++;
    if (gnt0 !== 8'h00 || idx0 !== 3'd0 || vld0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: gnt=%h idx=%0d vld=%b expected 00/0/0", gnt0, idx0, vld0);
    end
    rst_n = 1'b1;
    req0 = 8'h81;
    step();
    vectors++;
    if (gnt0 !== 8'h01 || idx0 !== 3'd0 || vld0 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ptr0: gnt=%h idx=%0d vld=%b expected 01/0/1", gnt0, idx0, vld0);
    end
    req0 = 8'h00;
    step();
    vectors++;
    if (gnt0 !== 8'h00 || vld0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: gnt=%h vld=%b expected 00/0", gnt0, vld0);
    end
  endtask

  task automatic test_single_client();
    req0 = 8'h04;
    #2;
    vectors++;
    if (gnt0 !== 8'h00) begin
      miscompares++;
      $display("FAIL single_latency: gnt=%h before edge, expected 00", gnt0);
    end
    step();
    vectors++;
    if (gnt0 !== 8'h04 || idx0 !== 3'd2 || vld0 !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant: gnt=%h idx=%0d vld=%b expected 04/2/1", gnt0, idx0, vld0);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      vectors++;
      if (gnt0 !== 8'h04 || idx0 !== 3'd2) begin
        miscompares++;
        $display("FAIL single_hold[%0d]: gnt=%h idx=%0d expected 04/2", c, gnt0, idx0);
      end
    end
    req0 = 8'h00;
    step();
    vectors++;
    if (gnt0 !== 8'h00 || idx0 !== 3'd0 || vld0 !== 1'b0) begin
      miscompares++;
      $display("FAIL single_release: gnt=%h idx=%0d vld=%b expected 00/0/0", gnt0, idx0, vld0);
    end
  endtask

  task automatic test_encoding_sweep();
    logic [7:0] one_hot;
    for (int k = 0; k < 8; k++) begin
      one_hot = 8'b1 << k;
      req0 = one_hot;
      #2;
      vectors++;
      if (gnt0 !== 8'h00) begin
        miscompares++;
        $display("FAIL sweep_latency[%0d]: gnt=%h before edge, expected 00", k, gnt0);
      end
      step();
      vectors++;
      if (gnt0 !== one_hot || idx0 !== 3'(k) || vld0 !== 1'b1) begin
        miscompares++;
        $display("FAIL sweep_grant[%0d]: gnt=%h idx=%0d vld=%b expected %h/%0d/1",
                 k, gnt0, idx0, vld0, one_hot, k);
      end
      req0 = 8'h00;
      step();
      vectors++;
      if (gnt0 !== 8'h00 || vld0 !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep_release[%0d]: gnt=%h vld=%b expected 00/0", k, gnt0, vld0);
      end
    end
  endtask

  task automatic test_rotation();
    req0 = 8'h20;
    step();
    vectors++;
    if (idx0 !== 3'd5) begin
      miscompares++;
      $display("FAIL rot_grant5: idx=%0d expected 5", idx0);
    end
    req0 = 8'h00;
    step();
    req0 = 8'h21;
    step();
    vectors++;
    if (gnt0 !== 8'h01 || idx0 !== 3'd0) begin
      miscompares++;
      $display("FAIL rot_wrap: gnt=%h idx=%0d expected 01/0", gnt0, idx0);
    end
    req0 = 8'h00;
    step();
    req0 = 8'h21;
    step();
    vectors++;
    if (gnt0 !== 8'h20 || idx0 !== 3'd5) begin
      miscompares++;
      $display("FAIL rot_fair: gnt=%h idx=%0d expected 20/5", gnt0, idx0);
    end
    req0 = 8'h00;
    step();
  endtask

  task automatic test_back_to_back();
    // ptr is 6 after client 5 was released, so 8'h21 goes to client 0 first.
    req0 = 8'h21;
    step();
    vectors++;
    if (gnt0 !== 8'h01) begin
      miscompares++;
      $display("FAIL b2b_first: gnt=%h expected 01", gnt0);
    end
    req0 = 8'h20;
    step();
    vectors++;
    if (gnt0 !== 8'h20 || idx0 !== 3'd5 || vld0 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_handoff: gnt=%h idx=%0d vld=%b expected 20/5/1", gnt0, idx0, vld0);
    end
    req0 = 8'h02;
    step();
    vectors++;
    if (gnt0 !== 8'h02 || idx0 !== 3'd1) begin
      miscompares++;
      $display("FAIL b2b_swap: gnt=%h idx=%0d expected 02/1", gnt0, idx0);
    end
    req0 = 8'h00;
    step();
    vectors++;
    if (gnt0 !== 8'h00 || vld0 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: gnt=%h vld=%b expected 00/0", gnt0, vld0);
    end
  endtask

  task automatic test_preemption();
    logic [2:0] exp_idx;
    req4 = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      exp_idx = 3'(g % 8);
      for (int c = 0; c < 4; c++) begin
        step();
        vectors++;
        if (gnt4 !== (8'b1 << exp_idx) || idx4 !== exp_idx || vld4 !== 1'b1) begin
          miscompares++;
          $display("FAIL preempt[%0d.%0d]: gnt=%h idx=%0d vld=%b expected idx %0d",
                   g, c, gnt4, idx4, vld4, exp_idx);
        end
      end
    end
    req4 = 8'h00;
    step();
    vectors++;
    if (gnt4 !== 8'h00 || vld4 !== 1'b0) begin
      miscompares++;
      $display("FAIL preempt_idle: gnt=%h vld=%b expected 00/0", gnt4, vld4);
    end
  endtask

  task automatic test_no_contention();
    req2 = 8'h08;
    for (int c = 0; c < 10; c++) begin
      step();
      vectors++;
      if (gnt2 !== 8'h08 || idx2 !== 3'd3) begin
        miscompares++;
        $display("FAIL nocont_hold[%0d]: gnt=%h idx=%0d expected 08/3", c, gnt2, idx2);
      end
    end
    req2 = 8'h0A;
    step();
    vectors++;
    if (gnt2 !== 8'h02 || idx2 !== 3'd1) begin
      miscompares++;
      $display("FAIL nocont_preempt: gnt=%h idx=%0d expected 02/1", gnt2, idx2);
    end
    req2 = 8'h00;
    step();
    vectors++;
    if (gnt2 !== 8'h00 || vld2 !== 1'b0) begin
      miscompares++;
      $display("FAIL nocont_idle: gnt=%h vld=%b expected 00/0", gnt2, vld2);
    end
  endtask

  initial begin
    test_reset();
    test_single_client();
    test_encoding_sweep();
    test_rotation();
    test_back_to_back();
    test_preemption();
    test_no_contention();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
